// File: rtl/membus_avl_master.sv
// Avalon-MM slave that lets the HPS run single read/write cycles on a
// PDP-10 core memory bus, acting as the request side of the membus.
module membus_avl_master #(
  parameter int TIMEOUT = 1000,
  parameter int CNT_W   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  s_address,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic        membus_rq_cyc,
  output logic        membus_rd_rq,
  output logic        membus_wr_rq,
  output logic [14:0] membus_ma,
  output logic [3:0]  membus_sel,
  output logic        membus_fmc_select,
  output logic        membus_wr_rs,
  output logic [35:0] membus_mb_out,
  input  logic        membus_addr_ack,
  input  logic        membus_rd_rs,
  input  logic [35:0] membus_mb_in
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WDATA, S_RWAIT} state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [19:0]        addr_q, addr_d;
  logic [17:0]        dlo_q, dlo_d, dhi_q, dhi_d;
  logic               err_q, err_d, done_q, done_d, wr_q, wr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               busy, reg_we;
  logic [11:0]        unused_wdata;

  assign unused_wdata = s_writedata[31:20];
  assign busy         = (state_q != S_IDLE);
  assign reg_we       = s_write && !busy;
  assign s_readdata   = rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      dlo_q   <= '0;
      dhi_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dlo_q   <= dlo_d;
      dhi_q   <= dhi_d;
      err_q   <= err_d;
      done_q  <= done_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      if (s_read) rdata_q <= rdata_d;
    end
  end

  always_comb begin
    rdata_d = '0;
    unique case (s_address)
      2'd0: rdata_d[19:0] = addr_q;
      2'd1: rdata_d[17:0] = dlo_q;
      2'd2: rdata_d[17:0] = dhi_q;
      2'd3: rdata_d[2:0]  = {done_q, err_q, busy};
    endcase
  end

  always_comb begin
    state_d           = state_q;
    addr_d            = addr_q;
    dlo_d             = dlo_q;
    dhi_d             = dhi_q;
    err_d             = err_q;
    done_d            = done_q;
    wr_d              = wr_q;
    cnt_d             = cnt_q;
    membus_rq_cyc     = 1'b0;
    membus_rd_rq      = 1'b0;
    membus_wr_rq      = 1'b0;
    membus_ma         = '0;
    membus_sel        = '0;
    membus_fmc_select = 1'b0;
    membus_wr_rs      = 1'b0;
    membus_mb_out     = '0;

    // Register writes only land in IDLE; the FSM arms below never overlap them.
    if (reg_we) begin
      unique case (s_address)
        2'd0: addr_d = s_writedata[19:0];
        2'd1: dlo_d  = s_writedata[17:0];
        2'd2: dhi_d  = s_writedata[17:0];
        2'd3: begin
          err_d  = 1'b0;
          done_d = 1'b0;
          if (s_writedata[0] && s_writedata[1]) begin
            err_d = 1'b1;
          end else if (s_writedata[0] || s_writedata[1]) begin
            wr_d    = s_writedata[1];
            cnt_d   = '0;
            state_d = S_REQ;
          end
        end
      endcase
    end

    unique case (state_q)
      S_IDLE: ;
      S_REQ: begin
        membus_rq_cyc     = 1'b1;
        membus_rd_rq      = !wr_q;
        membus_wr_rq      = wr_q;
        {membus_fmc_select, membus_sel, membus_ma} = addr_q;
        if (wr_q) membus_mb_out = {dhi_q, dlo_q};
        cnt_d = cnt_q + 1'b1;
        if (membus_addr_ack) begin
          if (wr_q) begin
            state_d = S_WDATA;
          end else if (membus_rd_rs) begin
            {dhi_d, dlo_d} = membus_mb_in;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d   = '0;
            state_d = S_RWAIT;
          end
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_WDATA: begin
        membus_wr_rs  = 1'b1;
        membus_mb_out = {dhi_q, dlo_q};
        {membus_fmc_select, membus_sel, membus_ma} = addr_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_RWAIT: begin
        {membus_fmc_select, membus_sel, membus_ma} = addr_q;
        cnt_d = cnt_q + 1'b1;
        if (membus_rd_rs) begin
          {dhi_d, dlo_d} = membus_mb_in;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_membus_avl_master.sv
// Randomized bench for membus_avl_master: a register/memory reference model
// feeds expected Avalon reads and membus cycles into queues checked by monitors.
module tb_membus_avl_master;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  s_address = '0;
  logic        s_read = 1'b0, s_write = 1'b0;
  logic [31:0] s_writedata = '0;
  logic [31:0] s_readdata;
  logic        membus_rq_cyc, membus_rd_rq, membus_wr_rq, membus_fmc_select, membus_wr_rs;
  logic [14:0] membus_ma;
  logic [3:0]  membus_sel;
  logic [35:0] membus_mb_out;
  logic        membus_addr_ack = 1'b0, membus_rd_rs = 1'b0;
  logic [35:0] membus_mb_in = '0;

  membus_avl_master #(.TIMEOUT(TO), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .s_address(s_address), .s_read(s_read),
    .s_write(s_write), .s_writedata(s_writedata), .s_readdata(s_readdata),
    .membus_rq_cyc(membus_rq_cyc), .membus_rd_rq(membus_rd_rq),
    .membus_wr_rq(membus_wr_rq), .membus_ma(membus_ma), .membus_sel(membus_sel),
    .membus_fmc_select(membus_fmc_select), .membus_wr_rs(membus_wr_rs),
    .membus_mb_out(membus_mb_out), .membus_addr_ack(membus_addr_ack),
    .membus_rd_rs(membus_rd_rs), .membus_mb_in(membus_mb_in)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic        is_wr;
    logic [14:0] ma;
    logic [3:0]  sel;
    logic        fmc;
    logic [35:0] data;
    int          rq_len;
    logic        wrs;
  } bus_t;

  bus_t        bus_q[$];
  logic [31:0] rd_q[$];
  int          n_chk = 0, n_err = 0;

  // reference model of the register file
  logic [19:0] m_addr = '0;
  logic [17:0] m_dlo = '0, m_dhi = '0;
  logic        m_err = 1'b0, m_done = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_reg(input logic [1:0] a);
    case (a)
      2'd0:    return {12'b0, m_addr};
      2'd1:    return {14'b0, m_dlo};
      2'd2:    return {14'b0, m_dhi};
      default: return {29'b0, m_done, m_err, 1'b0};
    endcase
  endfunction

  // Avalon read monitor: data is due the cycle after s_read is sampled
  logic rd_pend = 1'b0;
  always @(posedge clk) rd_pend <= s_read && !reset;
  always @(negedge clk) begin
    if (rd_pend) begin
      if (rd_q.size() == 0) chk("avl_rd_unexpected", 64'(s_readdata), 64'hDEAD);
      else chk("avl_rd", 64'(s_readdata), 64'(rd_q.pop_front()));
    end
  end

  // membus monitor: collects one request phase, checks it when rq_cyc drops
  logic        in_rq = 1'b0, cap_rd, cap_wr, cap_fmc, stable;
  logic [14:0] cap_ma;
  logic [3:0]  cap_sel;
  logic [35:0] cap_mb;
  int          rq_n = 0, rq_total = 0;
  always @(negedge clk) begin
    if (membus_rq_cyc) begin
      rq_total++;
      if (!in_rq) begin
        in_rq = 1'b1; rq_n = 0; stable = 1'b1;
        cap_rd = membus_rd_rq; cap_wr = membus_wr_rq; cap_ma = membus_ma;
        cap_sel = membus_sel; cap_fmc = membus_fmc_select; cap_mb = membus_mb_out;
      end else if (membus_ma != cap_ma || membus_sel != cap_sel ||
                   membus_fmc_select != cap_fmc || membus_mb_out != cap_mb ||
                   membus_rd_rq != cap_rd || membus_wr_rq != cap_wr) begin
        stable = 1'b0;
      end
      rq_n++;
    end else if (in_rq) begin
      bus_t e;
      in_rq = 1'b0;
      if (bus_q.size() == 0) begin
        chk("bus_unexpected_rq", 64'(rq_n), 64'd0);
      end else begin
        e = bus_q.pop_front();
        chk("bus_rq_len", 64'(rq_n), 64'(e.rq_len));
        chk("bus_req_lines", {62'b0, cap_rd, cap_wr}, {62'b0, !e.is_wr, e.is_wr});
        chk("bus_addr", {44'b0, cap_fmc, cap_sel, cap_ma}, {44'b0, e.fmc, e.sel, e.ma});
        chk("bus_req_mb_out", 64'(cap_mb), 64'(e.is_wr ? e.data : 36'd0));
        chk("bus_stable", 64'(stable), 64'd1);
        chk("bus_wr_rs", 64'(membus_wr_rs), 64'(e.wrs));
        chk("bus_wdata_mb_out", 64'(membus_mb_out), 64'(e.wrs ? e.data : 36'd0));
      end
    end
  end

  task automatic avl_wr(input logic [1:0] a, input logic [31:0] d);
    s_write = 1'b1; s_address = a; s_writedata = d;
    @(negedge clk);
    s_write = 1'b0;
  endtask

  // write while idle, applying the register rules to the model
  task automatic mwr(input logic [1:0] a, input logic [31:0] d);
    case (a)
      2'd0: m_addr = d[19:0];
      2'd1: m_dlo  = d[17:0];
      2'd2: m_dhi  = d[17:0];
      default: begin
        m_err = 1'b0; m_done = 1'b0;
        if (d[1:0] == 2'b11) m_err = 1'b1;
      end
    endcase
    avl_wr(a, d);
  endtask

  task automatic mrd(input logic [1:0] a);
    s_read = 1'b1; s_address = a;
    rd_q.push_back(exp_reg(a));
    @(negedge clk);
    s_read = 1'b0;
  endtask

  task automatic rnd_mb();
    logic [63:0] t;
    t = {$urandom, $urandom};
    membus_mb_in = t[35:0];
  endtask

  task automatic do_cycle(input logic is_wr, input int ack_k, input int rd_k,
                          input logic same, input logic [35:0] data,
                          input logic poke, input int rst_at);
    bus_t e;
    logic ack_ok, rd_ok, did_rst;
    int   n, m;
    ack_ok   = (ack_k + 1 <= TO);
    rd_ok    = (rd_k + 1 <= TO);
    did_rst  = 1'b0;
    e.is_wr  = is_wr;
    e.ma     = m_addr[14:0];
    e.sel    = m_addr[18:15];
    e.fmc    = m_addr[19];
    e.data   = {m_dhi, m_dlo};
    e.rq_len = ack_ok ? ack_k + 1 : TO;
    e.wrs    = is_wr && ack_ok;
    bus_q.push_back(e);
    mwr(2'd3, is_wr ? 32'd2 : 32'd1);
    n = 1;
    while (1) begin
      rnd_mb();
      if (n == 1) begin
        s_read = 1'b1; s_address = 2'd3; rd_q.push_back(32'h1);
      end
      if (n == 2 && poke) begin
        s_write = 1'b1; s_address = 2'd0; s_writedata = $urandom;
      end
      if (ack_ok && n == ack_k + 1) begin
        membus_addr_ack = 1'b1;
        if (!is_wr && same) begin membus_rd_rs = 1'b1; membus_mb_in = data; end
      end
      @(negedge clk);
      s_read = 1'b0; s_write = 1'b0; membus_addr_ack = 1'b0; membus_rd_rs = 1'b0;
      if ((ack_ok && n == ack_k + 1) || n == TO) break;
      n++;
    end
    if (!ack_ok) begin
      m_err = 1'b1; m_done = 1'b0;
    end else if (is_wr) begin
      m_done = 1'b1;
      membus_addr_ack = 1'b1; membus_rd_rs = 1'b1; rnd_mb();
      @(negedge clk);
      membus_addr_ack = 1'b0; membus_rd_rs = 1'b0;
    end else if (same) begin
      {m_dhi, m_dlo} = data; m_done = 1'b1;
    end else begin
      m = 1;
      while (1) begin
        rnd_mb();
        if (rst_at != 0 && m == rst_at) begin
          reset = 1'b1;
          @(negedge clk);
          reset = 1'b0;
          chk("rst_mid_bus", {membus_rq_cyc, membus_rd_rq, membus_wr_rq, membus_fmc_select,
                              membus_wr_rs, membus_sel, membus_ma}, 64'd0);
          chk("rst_mid_mb_out", 64'(membus_mb_out), 64'd0);
          chk("rst_mid_readdata", 64'(s_readdata), 64'd0);
          m_addr = '0; m_dlo = '0; m_dhi = '0; m_err = 1'b0; m_done = 1'b0;
          membus_rd_rs = 1'b1; membus_mb_in = data;
          @(negedge clk);
          membus_rd_rs = 1'b0;
          did_rst = 1'b1;
          break;
        end
        if (rd_ok && m == rd_k + 1) begin membus_rd_rs = 1'b1; membus_mb_in = data; end
        @(negedge clk);
        membus_rd_rs = 1'b0;
        if ((rd_ok && m == rd_k + 1) || m == TO) break;
        m++;
      end
      if (!did_rst) begin
        if (rd_ok) begin {m_dhi, m_dlo} = data; m_done = 1'b1; end
        else begin m_err = 1'b1; m_done = 1'b0; end
      end
    end
    mrd(2'd3);
    // stray acknowledges while idle must be ignored
    membus_addr_ack = 1'b1; membus_rd_rs = 1'b1; rnd_mb();
    @(negedge clk);
    membus_addr_ack = 1'b0; membus_rd_rs = 1'b0;
    mrd(2'd1); mrd(2'd2); mrd(2'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    logic [63:0] t;
    repeat (3) @(negedge clk);
    chk("rst_bus", {membus_rq_cyc, membus_rd_rq, membus_wr_rq, membus_fmc_select,
                    membus_wr_rs, membus_sel, membus_ma}, 64'd0);
    chk("rst_mb_out", 64'(membus_mb_out), 64'd0);
    chk("rst_readdata", 64'(s_readdata), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    for (int a = 0; a < 4; a++) mrd(2'(a));

    // directed write cycle, memory acks on the fourth request cycle
    mwr(2'd0, 32'h12345); mwr(2'd2, 32'h3FFFF); mwr(2'd1, 32'h00001);
    do_cycle(1'b1, 3, 0, 1'b0, 36'd0, 1'b1, 0);
    // directed read and same-cycle acknowledge read
    do_cycle(1'b0, 2, 2, 1'b0, 36'h123456789, 1'b0, 0);
    do_cycle(1'b0, 0, 0, 1'b1, 36'hABCDE1234, 1'b1, 0);
    // timeouts in REQ and in RWAIT, then clear with a CSR write of 0
    do_cycle(1'b0, 20, 0, 1'b0, 36'h0, 1'b1, 0);
    mwr(2'd3, 32'd0); mrd(2'd3);
    do_cycle(1'b1, 20, 0, 1'b0, 36'h0, 1'b0, 0);
    do_cycle(1'b0, 1, 9, 1'b0, 36'h0, 1'b0, 0);
    mwr(2'd3, 32'd0); mrd(2'd3);
    // ack on the last allowed cycle still wins over the timeout
    do_cycle(1'b0, TO - 1, TO - 1, 1'b0, 36'h876543210, 1'b0, 0);
    // both start bits: error, no bus cycle
    snap = rq_total;
    mwr(2'd3, 32'd3);
    repeat (5) @(negedge clk);
    chk("illegal_no_rq", 64'(rq_total), 64'(snap));
    mrd(2'd3);

    for (int it = 0; it < 30; it++) begin
      logic w, sm;
      if ($urandom_range(1, 0) == 1) mwr(2'd0, $urandom);
      mwr(2'd1, $urandom); mwr(2'd2, $urandom);
      w  = 1'($urandom_range(1, 0));
      sm = !w && ($urandom_range(3, 0) == 0);
      t  = {$urandom, $urandom};
      do_cycle(w, $urandom_range(9, 0), $urandom_range(9, 0), sm, t[35:0],
               1'($urandom_range(1, 0)), 0);
    end

    // reset while waiting for rd_rs, followed by a late rd_rs
    mwr(2'd0, 32'hABCDE); mwr(2'd1, 32'h1111); mwr(2'd2, 32'h2222);
    do_cycle(1'b0, 1, 6, 1'b0, 36'hFEDCBA987, 1'b0, 2);

    repeat (3) @(negedge clk);
    chk("bus_q_drained", 64'(bus_q.size()), 64'd0);
    chk("rd_q_drained", 64'(rd_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
